alu_8: RTL and testbench

- 8-bit, 4-function ALU (ADD, AND, OR, XOR) for the CPU datapath.
- Sits between the register file read ports and the writeback mux.
- Operands and opcode are sampled on a clock edge; result and flags are registered with a 1-cycle latency.
- The adder is a structural ripple-carry chain of 1-bit full adders built from 2-input gates; logic ops are bitwise.

---
 rtl/alu_8.sv | 129 ++++++++++++
 tb/tb_alu_8.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_8
// Description : Registered 4-function ALU (ADD/AND/OR/XOR) with a gate-level
//               ripple-carry adder. Optional zero/negative/overflow flags are
//               enabled by defining ALU8_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             half_carry,
`ifdef ALU8_FLAGS_EN
    output logic             zero,
    output logic             negative,
    output logic             overflow,
`endif
    output logic             out_valid
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_OR  = 2'b10;
    localparam logic [1:0] c_OP_XOR = 2'b11;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_y;
    logic             w_carry;
    logic             w_half;

    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_half;
    logic             r_out_valid;

    assign w_c[0] = 1'b0;

    // One full adder per bit, built only from 2-input gates.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_fa
            logic w_p;
            logic w_g;
            logic w_pc;
            assign w_p        = a[i] ^ b[i];
            assign w_g        = a[i] & b[i];
            assign w_pc       = w_p & w_c[i];
            assign w_sum[i]   = w_p ^ w_c[i];
            assign w_c[i+1]   = w_g | w_pc;
        end
    endgenerate

    always_comb begin
        w_y     = '0;
        w_carry = 1'b0;
        w_half  = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_y     = w_sum;
                w_carry = w_c[WIDTH];
                w_half  = w_c[4];
            end
            c_OP_AND: w_y = a & b;
            c_OP_OR:  w_y = a | b;
            c_OP_XOR: w_y = a ^ b;
            default:  w_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_carry     <= 1'b0;
            r_half      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y     <= w_y;
                r_carry <= w_carry;
                r_half  <= w_half;
            end
        end
    end

    assign y          = r_y;
    assign carry      = r_carry;
    assign half_carry = r_half;
    assign out_valid  = r_out_valid;

`ifdef ALU8_FLAGS_EN
    logic w_overflow;
    logic r_zero;
    logic r_negative;
    logic r_overflow;

    // Signed overflow: operands agree in sign but the sum's sign differs.
    assign w_overflow = (op == c_OP_ADD) && (a[WIDTH-1] == b[WIDTH-1])
                        && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (in_valid) begin
            r_zero     <= (w_y == '0);
            r_negative <= w_y[WIDTH-1];
            r_overflow <= w_overflow;
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_8
// Description : Self-checking bench for alu_8 against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] y;
    logic       carry;
    logic       half_carry;
    logic       out_valid;
`ifdef ALU8_FLAGS_EN
    logic       zero;
    logic       negative;
    logic       overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .op         (op),
        .y          (y),
        .carry      (carry),
        .half_carry (half_carry),
`ifdef ALU8_FLAGS_EN
        .zero       (zero),
        .negative   (negative),
        .overflow   (overflow),
`endif
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the sampled inputs.
    int   m_init = 0;
    int   m_y, m_c, m_h, m_v, m_z, m_n, m_o;
    int   s_u, s_s;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1;
            m_y = 0; m_c = 0; m_h = 0; m_v = 0; m_z = 0; m_n = 0; m_o = 0;
        end else begin
            m_v = in_valid ? 1 : 0;
            if (in_valid) begin
                m_c = 0; m_h = 0; m_o = 0;
                case (op)
                    2'b00: begin
                        s_u = int'(a) + int'(b);
                        s_s = int'($signed(a)) + int'($signed(b));
                        m_y = s_u % 256;
                        m_c = (s_u > 255) ? 1 : 0;
                        m_h = ((int'(a) % 16 + int'(b) % 16) > 15) ? 1 : 0;
                        m_o = (s_s > 127 || s_s < -128) ? 1 : 0;
                    end
                    2'b01: m_y = int'(a & b);
                    2'b10: m_y = int'(a | b);
                    default: m_y = int'(a ^ b);
                endcase
                m_z = (m_y == 0) ? 1 : 0;
                m_n = (m_y >= 128) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init != 0) begin
            n_vec++;
            chk("out_valid", 32'(out_valid), 32'(m_v));
            chk("y", 32'(y), 32'(m_y));
            chk("carry", 32'(carry), 32'(m_c));
            chk("half_carry", 32'(half_carry), 32'(m_h));
`ifdef ALU8_FLAGS_EN
            chk("zero", 32'(zero), 32'(m_z));
            chk("negative", 32'(negative), 32'(m_n));
            chk("overflow", 32'(overflow), 32'(m_o));
`endif
        end
    end

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                         input logic tv, input logic tr);
        a = ta; b = tb; op = top; in_valid = tv; rst = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] ey, input logic ec,
                       input logic eh, input logic ev);
        chk({name, ".y"}, 32'(y), 32'(ey));
        chk({name, ".carry"}, 32'(carry), 32'(ec));
        chk({name, ".half_carry"}, 32'(half_carry), 32'(eh));
        chk({name, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd5; op = 2'b00;
        drive(8'd3, 8'd5, 2'b00, 1'b1, 1'b1);
        drive(8'd3, 8'd5, 2'b00, 1'b1, 1'b1);
        lit("reset", 8'd0, 1'b0, 1'b0, 1'b0);

        drive(8'd3, 8'd5, 2'b00, 1'b1, 1'b0);   lit("add3_5", 8'd8, 1'b0, 1'b0, 1'b1);
        drive(8'd7, 8'd8, 2'b00, 1'b1, 1'b0);   lit("add7_8", 8'd15, 1'b0, 1'b0, 1'b1);
        drive(8'd15, 8'd1, 2'b00, 1'b1, 1'b0);  lit("add15_1", 8'd16, 1'b0, 1'b1, 1'b1);
        drive(8'd255, 8'd1, 2'b00, 1'b1, 1'b0); lit("add255_1", 8'd0, 1'b1, 1'b1, 1'b1);
`ifdef ALU8_FLAGS_EN
        chk("add255_1.zero", 32'(zero), 32'd1);
        chk("add255_1.overflow", 32'(overflow), 32'd0);
`endif
        drive(8'd255, 8'd255, 2'b00, 1'b1, 1'b0); lit("add255_255", 8'd254, 1'b1, 1'b1, 1'b1);
        drive(8'd127, 8'd1, 2'b00, 1'b1, 1'b0);   lit("add127_1", 8'd128, 1'b0, 1'b1, 1'b1);
`ifdef ALU8_FLAGS_EN
        chk("add127_1.overflow", 32'(overflow), 32'd1);
        chk("add127_1.negative", 32'(negative), 32'd1);
`endif
        drive(8'd3, 8'd5, 2'b01, 1'b1, 1'b0);  lit("and", 8'd1, 1'b0, 1'b0, 1'b1);
        drive(8'd7, 8'd8, 2'b10, 1'b1, 1'b0);  lit("or", 8'd15, 1'b0, 1'b0, 1'b1);
        drive(8'd15, 8'd1, 2'b11, 1'b1, 1'b0); lit("xor", 8'd14, 1'b0, 1'b0, 1'b1);

        drive(8'd15, 8'd1, 2'b00, 1'b1, 1'b0); lit("hold_acc", 8'd16, 1'b0, 1'b1, 1'b1);
        drive(8'd0, 8'd0, 2'b00, 1'b0, 1'b0);  lit("hold", 8'd16, 1'b0, 1'b1, 1'b0);
        drive(8'd9, 8'd9, 2'b00, 1'b1, 1'b1);  lit("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            drive(8'($urandom), 8'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end
        drive(8'd0, 8'd0, 2'b00, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
